// File: rtl/lfsr_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_checker : locks onto a received LFSR word stream and counts mismatches
// Rev 1.0
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int               WIDTH        = 3,
  parameter logic [WIDTH-1:0] STATIC_TAPS  = 3'b101,
  parameter int               LOCK_COUNT   = 4,
  parameter int               UNLOCK_COUNT = 3,
  parameter int               CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 use_config_lfsr,
  input  logic [WIDTH-1:0]     config_taps,
  input  logic [WIDTH-1:0]     lfsr_in,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 zero_seen
);

  localparam int c_MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int c_UW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
  localparam logic [c_MW-1:0] c_LOCK_LAST   = c_MW'(LOCK_COUNT - 1);
  localparam logic [c_UW-1:0] c_UNLOCK_LAST = c_UW'(UNLOCK_COUNT - 1);
  localparam logic [c_MW-1:0] c_M_ONE       = c_MW'(1);
  localparam logic [c_UW-1:0] c_U_ONE       = c_UW'(1);
  localparam logic [CNT_WIDTH-1:0] c_E_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_ref;
  logic [WIDTH-1:0]     w_ref_nxt;
  logic [c_MW-1:0]      r_match_cnt;
  logic [c_MW-1:0]      w_match_nxt;
  logic [c_UW-1:0]      r_miss_cnt;
  logic [c_UW-1:0]      w_miss_nxt;
  logic [WIDTH-1:0]     r_taps;
  logic                 r_taps_vld;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] w_err_cnt_nxt;
  logic                 r_zero_seen;

  logic [WIDTH-1:0]     w_taps;
  logic [WIDTH-1:0]     w_pred;
  logic                 w_in_zero;
  logic                 w_match;
  logic                 w_tap_change;
  logic                 w_err_evt;

  assign w_taps       = use_config_lfsr ? config_taps : STATIC_TAPS;
  assign w_pred       = {r_ref[WIDTH-2:0], ^(r_ref & w_taps)};
  assign w_in_zero    = (lfsr_in == '0);
  // A zero word is never a valid LFSR state, so it can never count as a match.
  assign w_match      = (lfsr_in == w_pred) && !w_in_zero;
  assign w_tap_change = r_taps_vld && (w_taps != r_taps);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SEARCH;
      r_ref       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_taps      <= '0;
      r_taps_vld  <= 1'b0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
      r_zero_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref       <= w_ref_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_taps      <= w_taps;
      r_taps_vld  <= 1'b1;
      r_error     <= w_err_evt;
      r_err_cnt   <= w_err_cnt_nxt;
      if (enable && w_in_zero) begin
        r_zero_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_evt   = 1'b0;
    if (w_tap_change) begin
      w_state_nxt = ST_SEARCH;
      w_match_nxt = '0;
      w_miss_nxt  = '0;
    end else if (enable) begin
      unique case (r_state)
        ST_SEARCH: begin
          if (!w_in_zero) begin
            w_ref_nxt   = lfsr_in;
            w_match_nxt = '0;
            w_state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          w_ref_nxt = lfsr_in;
          if (!w_match) begin
            w_match_nxt = '0;
          end else if (r_match_cnt == c_LOCK_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
          end else begin
            w_match_nxt = r_match_cnt + c_M_ONE;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_ref_nxt  = lfsr_in;
            w_miss_nxt = '0;
          end else begin
            // Flywheel on the prediction so one corrupted word costs one error.
            w_ref_nxt = w_pred;
            w_err_evt = 1'b1;
            if (r_miss_cnt == c_UNLOCK_LAST) begin
              w_state_nxt = ST_SEARCH;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = r_miss_cnt + c_U_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_match_nxt = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (clr_count) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_evt && (r_err_cnt != '1)) begin
      w_err_cnt_nxt = r_err_cnt + c_E_ONE;
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign error     = r_error;
  assign err_count = r_err_cnt;
  assign zero_seen = r_zero_seen;

endmodule
`default_nettype wire
